tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Parametrised successor to the SNN timestep tick generator. Emits one-cycle `tick` pulses that advance the spiking-neuron timestep across a grid of NUM_CORES cores.
- Tick sources: quiescence detection (all input/forward buffers empty and all cores idle for a programmable number of cycles), a programmable periodic timer, or both.
- A drain phase issues periodic ticks until the grid reports completion.
- Sits between the input buffer / NoC status signals and the neuron-core array.

Parameters:
- NUM_CORES, 4, number of cores/channels whose idle and forward-buffer-empty flags are monitored
- QUIET_W, 4, width of quiescence threshold and counter
- PERIOD_W, 32, width of periodic timer and period register
- TSTEP_W, 16, width of timestep counter output

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous reset, active-high
- enable  in  1  block enable; low forces IDLE
- mode  in  2  0=quiescence only, 1=periodic only, 2=hybrid, 3=reserved (behaves as 0)
- quiet_thresh  in  QUIET_W  consecutive quiet cycles required before a tick
- period  in  PERIOD_W  periodic tick interval in cycles
- input_buffer_empty  in  1  spike input buffer empty
- core_idle  in  NUM_CORES  per-core idle flag
- fwd_empty  in  NUM_CORES  per-core forward/north/local buffers empty
- drain_req  in  1  controller request to enter drain phase
- complete  in  1  grid finished; ends drain phase
- tick  out  1  registered one-cycle timestep pulse
- tick_count  out  TSTEP_W  number of ticks issued since leaving IDLE, wraps
- state_o  out  2  current FSM state (IDLE=0, ACTIVE=1, DRAIN=2)
- busy  out  1  state_o != IDLE

Behaviour:
- Reset (any cycle, including mid-operation): next edge gives state IDLE, tick=0, tick_count=0, quiet_cnt=0, per_cnt=0. Outputs are held through reset.
- quiet = input_buffer_empty & (&core_idle) & (&fwd_empty), evaluated combinationally each cycle.
- Effective thresholds: quiet_thresh==0 is treated as 1; period==0 is treated as 1.
- tick is registered: a fire condition in cycle N gives tick=1 in cycle N+1, for exactly one cycle. tick_count increments in the same cycle tick is asserted and wraps at 2^TSTEP_W-1 -> 0.
- IDLE:
  - Counters are held at 0.
  - Go to ACTIVE when enable & (mode==1 | !input_buffer_empty).
- ACTIVE:
  - Quiescence source (mode 0/2/3):
    - quiet cycle: quiet_cnt+1.
    - non-quiet cycle: quiet_cnt cleared to 0. No decrement.
    - Fire when quiet & quiet_cnt==thr-1, then clear quiet_cnt. quiet_cnt never exceeds thr-1.
  - Periodic source (mode 1/2): per_cnt+1 each cycle; fire when per_cnt==period_eff-1, then clear.
  - Hybrid: a fire from either source produces a single tick. Any tick clears both counters, so the sources never produce back-to-back duplicate ticks.
  - drain_req=1: go to DRAIN next cycle. Both counters clear on entry; a tick fired in the same cycle is still issued.
- DRAIN:
  - Periodic ticks every period_eff cycles regardless of mode and quiet.
  - complete=1: go to IDLE. No tick fires that cycle, even if per_cnt hits its terminal count. per_cnt clears.
  - tick_count resets to 0 on the next transition IDLE->ACTIVE, not on entry to IDLE. It stays readable after completion.
- enable=0 in any non-IDLE state: IDLE next cycle, counters clear, no tick fires that cycle.
- Priority per cycle: reset > !enable > complete (DRAIN) > drain_req (ACTIVE) > tick fire.
- complete outside DRAIN is ignored. drain_req in IDLE is ignored.
- Inputs sampled only on clk; no combinational path from inputs to tick.
- quiet_thresh, period and mode changes take effect on the next compare. Counters are not reset by a change. If per_cnt is already > period_eff-1, it counts on until it wraps, then compares normally.

Test Plan:
- Reset/IDLE: reset held 3 cycles, then enable=1, input_buffer_empty=1, mode=0 for 20 cycles -> tick=0, busy=0, tick_count=0.
- Quiescence tick: mode=0, quiet_thresh=7. input_buffer_empty=0 one cycle, then all quiet -> first tick exactly 8 cycles after the first quiet cycle. Next tick 7 cycles after that. Inject one non-quiet cycle at quiet_cnt=5 -> tick delayed a full 7 quiet cycles. tick_count=1,2.
- Periodic and hybrid: mode=1, period=1004 -> ticks spaced 1004 cycles. mode=2, period=10, quiet_thresh=4, always quiet -> ticks every 4 cycles, never two ticks within 4 cycles.
- Drain and complete: ACTIVE, drain_req pulse, period=5 -> ticks every 5 cycles in DRAIN. Assert complete on the cycle per_cnt==4 -> no tick, state_o=0 next cycle, tick_count retained.
- Abort and reset mid-run: mid-DRAIN drop enable -> IDLE next cycle, no tick. Repeat with reset=1 -> all outputs 0 next edge.
- Edge values: quiet_thresh=0 and period=0 -> tick every cycle while quiet/active. tick_count wraps 65535->0 with TSTEP_W=16.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Generates one-cycle timestep pulses for a grid of spiking-neuron cores.
//   A tick comes from quiescence detection (input buffer, core and forward
//   buffers all idle for a programmable number of cycles), from a periodic
//   timer, or from either of them. A drain phase issues periodic ticks until
//   the grid reports completion.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous reset, active high
//   enable              block enable; low returns the scheduler to IDLE
//   mode                0 quiescence, 1 periodic, 2 hybrid, 3 same as 0
//   quiet_thresh        consecutive quiet cycles needed for a tick (0 acts as 1)
//   period              periodic tick interval in cycles (0 acts as 1)
//   input_buffer_empty  spike input buffer is empty
//   core_idle           per-core idle flags
//   fwd_empty           per-core forward/north/local buffers empty
//   drain_req           request to enter the drain phase (ACTIVE only)
//   complete            grid finished; ends the drain phase (DRAIN only)
//   tick                registered one-cycle timestep pulse
//   tick_count          ticks issued since the last IDLE->ACTIVE, wraps
//   state_o             current state (IDLE=0, ACTIVE=1, DRAIN=2)
//   busy                state_o != IDLE
module tick_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int QUIET_W   = 4,
  parameter int PERIOD_W  = 32,
  parameter int TSTEP_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [QUIET_W-1:0]   quiet_thresh,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 input_buffer_empty,
  input  logic [NUM_CORES-1:0] core_idle,
  input  logic [NUM_CORES-1:0] fwd_empty,
  input  logic                 drain_req,
  input  logic                 complete,
  output logic                 tick,
  output logic [TSTEP_W-1:0]   tick_count,
  output logic [1:0]           state_o,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [QUIET_W-1:0]  Q_ONE = QUIET_W'(1'b1);
  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1'b1);
  localparam logic [TSTEP_W-1:0]  T_ONE = TSTEP_W'(1'b1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [QUIET_W-1:0]   quiet_cnt_r;
  logic [QUIET_W-1:0]   quiet_cnt_nxt_s;
  logic [PERIOD_W-1:0]  per_cnt_r;
  logic [PERIOD_W-1:0]  per_cnt_nxt_s;
  logic                 tick_r;
  logic [TSTEP_W-1:0]   tick_count_r;
  logic                 busy_r;

  logic                 quiet_s;
  logic [QUIET_W-1:0]   thr_m1_s;
  logic [PERIOD_W-1:0]  per_m1_s;
  logic                 q_src_s;
  logic                 p_src_s;
  logic                 q_hit_s;
  logic                 p_term_s;
  logic                 fire_s;
  logic                 clr_count_s;

  // Source selection, zero-threshold handling and terminal-count compares
  always_comb begin
    quiet_s  = input_buffer_empty & (&core_idle) & (&fwd_empty);
    // A zero threshold/period behaves as one, so the terminal count is 0.
    thr_m1_s = (quiet_thresh == '0) ? '0 : (quiet_thresh - Q_ONE);
    per_m1_s = (period == '0) ? '0 : (period - P_ONE);
    q_src_s  = (mode != 2'd1);
    p_src_s  = (mode == 2'd1) || (mode == 2'd2);
    q_hit_s  = q_src_s & quiet_s & (quiet_cnt_r == thr_m1_s);
    p_term_s = (per_cnt_r == per_m1_s);
  end

  // Next-state, counter updates and fire decision
  always_comb begin
    state_nxt_s     = state_r;
    quiet_cnt_nxt_s = quiet_cnt_r;
    per_cnt_nxt_s   = per_cnt_r;
    fire_s          = 1'b0;
    clr_count_s     = 1'b0;
    case (state_r)
      IDLE: begin
        quiet_cnt_nxt_s = '0;
        per_cnt_nxt_s   = '0;
        if (enable && ((mode == 2'd1) || !input_buffer_empty)) begin
          state_nxt_s = ACTIVE;
          clr_count_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_nxt_s     = IDLE;
          quiet_cnt_nxt_s = '0;
          per_cnt_nxt_s   = '0;
        end else begin
          // In hybrid mode both sources may hit together; they merge into one tick.
          fire_s = q_hit_s | (p_src_s & p_term_s);
          if (drain_req) begin
            state_nxt_s     = DRAIN;
            quiet_cnt_nxt_s = '0;
            per_cnt_nxt_s   = '0;
          end else if (fire_s) begin
            // Any tick restarts both sources so they cannot double up.
            quiet_cnt_nxt_s = '0;
            per_cnt_nxt_s   = '0;
          end else begin
            quiet_cnt_nxt_s = (q_src_s && quiet_s) ? (quiet_cnt_r + Q_ONE) : '0;
            per_cnt_nxt_s   = p_src_s ? (per_cnt_r + P_ONE) : '0;
          end
        end
      end
      DRAIN: begin
        quiet_cnt_nxt_s = '0;
        if (!enable || complete) begin
          state_nxt_s   = IDLE;
          per_cnt_nxt_s = '0;
        end else if (p_term_s) begin
          fire_s        = 1'b1;
          per_cnt_nxt_s = '0;
        end else begin
          per_cnt_nxt_s = per_cnt_r + P_ONE;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        quiet_cnt_nxt_s = '0;
        per_cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      quiet_cnt_r  <= '0;
      per_cnt_r    <= '0;
      tick_r       <= 1'b0;
      tick_count_r <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      quiet_cnt_r <= quiet_cnt_nxt_s;
      per_cnt_r   <= per_cnt_nxt_s;
      tick_r      <= fire_s;
      busy_r      <= (state_nxt_s != IDLE);
      // The count survives IDLE so it can be read after a drain completes.
      if (clr_count_s) begin
        tick_count_r <= '0;
      end else if (fire_s) begin
        tick_count_r <= tick_count_r + T_ONE;
      end else begin
        tick_count_r <= tick_count_r;
      end
    end
  end

  assign tick       = tick_r;
  assign tick_count = tick_count_r;
  assign state_o    = state_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler. Stimulus pushes the hand-computed cycle and
// count of every expected tick into a queue; a monitor pops one entry per
// observed tick. Non-tick state is checked directly after each phase.
module tb_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [3:0]  quiet_thresh;
  logic [31:0] period;
  logic        input_buffer_empty;
  logic [3:0]  core_idle;
  logic [3:0]  fwd_empty;
  logic        drain_req;
  logic        complete;
  logic        tick;
  logic [15:0] tick_count;
  logic [1:0]  state_o;
  logic        busy;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  tick_scheduler #(
    .NUM_CORES(4), .QUIET_W(4), .PERIOD_W(32), .TSTEP_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .quiet_thresh(quiet_thresh), .period(period),
    .input_buffer_empty(input_buffer_empty), .core_idle(core_idle),
    .fwd_empty(fwd_empty), .drain_req(drain_req), .complete(complete),
    .tick(tick), .tick_count(tick_count), .state_o(state_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index: inputs applied after posedge k are sampled at posedge k+1
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed tick must match the oldest expected tick
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: tick at cycle %0d count %0d, required no tick", cyc, tick_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || tick_count !== 16'(e.cnt)) begin
          n_fail++;
          $display("FAIL tick_match: tick at cycle %0d count %0d, required cycle %0d count %0d",
                   cyc, tick_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    exp_q.push_back(e);
  endtask

  initial begin
    int t;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; quiet_thresh = 4'd0; period = 32'd0;
    input_buffer_empty = 1'b1; core_idle = 4'hF; fwd_empty = 4'hF;
    drain_req = 1'b0; complete = 1'b0;

    // Reset, then enabled but quiet in mode 0: must stay idle
    cycles(3);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_count", {16'd0, tick_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; enable = 1'b1; mode = 2'd0;
    cycles(20);
    check("idle_state", {30'd0, state_o}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_count", {16'd0, tick_count}, 32'd0);

    // Quiescence, threshold 7, with one non-quiet cycle at quiet_cnt=5
    quiet_thresh = 4'd7; input_buffer_empty = 1'b0; t = cyc;
    push(t + 8, 1); push(t + 15, 2); push(t + 28, 3);
    cycles(1);
    input_buffer_empty = 1'b1;
    check("q_state", {30'd0, state_o}, 32'd1);
    check("q_busy", {31'd0, busy}, 32'd1);
    cycles(19);
    core_idle = 4'b1011;
    cycles(1);
    core_idle = 4'hF;
    cycles(8);
    enable = 1'b0;
    cycles(1);
    check("q_exit_state", {30'd0, state_o}, 32'd0);
    check("q_exit_count", {16'd0, tick_count}, 32'd3);

    // Periodic, period 1004
    mode = 2'd1; period = 32'd1004; enable = 1'b1; t = cyc;
    push(t + 1005, 1); push(t + 2009, 2);
    cycles(2010);
    enable = 1'b0;
    cycles(1);
    check("p_count", {16'd0, tick_count}, 32'd2);

    // Hybrid: quiet wins every 4 cycles, then periodic takes over when busy
    mode = 2'd2; period = 32'd10; quiet_thresh = 4'd4;
    input_buffer_empty = 1'b0; enable = 1'b1; t = cyc;
    push(t + 5, 1); push(t + 9, 2); push(t + 13, 3); push(t + 17, 4); push(t + 27, 5);
    cycles(1);
    input_buffer_empty = 1'b1;
    cycles(16);
    core_idle = 4'h0;
    cycles(11);
    enable = 1'b0; core_idle = 4'hF;
    cycles(1);
    check("h_count", {16'd0, tick_count}, 32'd5);

    // Drain with period 5, complete on the terminal cycle
    mode = 2'd0; quiet_thresh = 4'd15; period = 32'd5;
    input_buffer_empty = 1'b0; enable = 1'b1; t = cyc;
    push(t + 7, 1); push(t + 12, 2);
    cycles(1);
    input_buffer_empty = 1'b1; drain_req = 1'b1;
    cycles(1);
    drain_req = 1'b0;
    check("d_state", {30'd0, state_o}, 32'd2);
    check("d_busy", {31'd0, busy}, 32'd1);
    cycles(14);
    complete = 1'b1;
    cycles(1);
    complete = 1'b0;
    check("d_done_state", {30'd0, state_o}, 32'd0);
    check("d_done_tick", {31'd0, tick}, 32'd0);
    check("d_done_count", {16'd0, tick_count}, 32'd2);
    check("d_done_busy", {31'd0, busy}, 32'd0);

    // Abort a drain by dropping enable on a terminal cycle
    input_buffer_empty = 1'b0; t = cyc;
    cycles(1);
    input_buffer_empty = 1'b1; drain_req = 1'b1;
    cycles(1);
    drain_req = 1'b0;
    cycles(4);
    enable = 1'b0;
    cycles(1);
    check("ab_state", {30'd0, state_o}, 32'd0);
    check("ab_tick", {31'd0, tick}, 32'd0);
    check("ab_count", {16'd0, tick_count}, 32'd0);

    // Reset in the middle of a drain
    enable = 1'b1; input_buffer_empty = 1'b0; t = cyc;
    push(t + 7, 1);
    cycles(1);
    input_buffer_empty = 1'b1; drain_req = 1'b1;
    cycles(1);
    drain_req = 1'b0;
    cycles(9);
    reset = 1'b1;
    cycles(1);
    check("mr_state", {30'd0, state_o}, 32'd0);
    check("mr_tick", {31'd0, tick}, 32'd0);
    check("mr_count", {16'd0, tick_count}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; enable = 1'b0;
    cycles(1);

    // Zero threshold: a tick every quiet cycle, count wraps through 0
    mode = 2'd0; quiet_thresh = 4'd0; period = 32'd0;
    input_buffer_empty = 1'b0; enable = 1'b1; t = cyc;
    for (int k = 1; k <= 65537; k++) push(t + 1 + k, k & 16'hFFFF);
    cycles(1);
    input_buffer_empty = 1'b1;
    cycles(65537);
    enable = 1'b0;
    cycles(1);
    check("wrap_count", {16'd0, tick_count}, 32'd1);

    // Zero period: a tick every active cycle
    mode = 2'd1; enable = 1'b1; t = cyc;
    push(t + 2, 1); push(t + 3, 2); push(t + 4, 3);
    cycles(4);
    enable = 1'b0;
    cycles(2);
    check("p0_count", {16'd0, tick_count}, 32'd3);

    // Every expected tick must have appeared
    cycles(2);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_tick: no tick seen, required cycle %0d count %0d", e.cyc, e.cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
